// File: rtl/clk_gen_pkg.sv
// Shared definitions for the clock-enable generator: FSM encoding and sizing limits.
package clk_gen_pkg;

   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_WARMUP = 2'd1,
      ST_RUN    = 2'd2
   } state_e;

   localparam int DEF_DIV_W = 8;
   localparam int MAX_CH    = 8;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: free-running counter, shadow/active divider pair with
// wrap-aligned update, and registered tick / square-wave outputs.
module clk_div_chan
   import clk_gen_pkg::*;
#(
   parameter int DIV_W       = DEF_DIV_W,
   parameter int DEFAULT_DIV = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cnt_en_i,
   input  logic             div_wr_i,
   input  logic [DIV_W-1:0] div_val_i,
   output logic             tick_o,
   output logic             clk_out_o,
   output logic             pending_o
);

   function automatic logic [DIV_W-1:0] half_div(input logic [DIV_W-1:0] d);
      return d >> 1;
   endfunction

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] act_q, act_d;
   logic [DIV_W-1:0] shd_q, shd_d;
   logic             pend_q, pend_d;
   logic             tick_q, tick_d;
   logic             clko_q, clko_d;
   logic             at_wrap;
   logic             apply;

   always_comb begin
      at_wrap = (cnt_q == act_q);
      // A new divider only takes effect on a period boundary, or at once when idle.
      apply   = pend_q && (!cnt_en_i || at_wrap);
      cnt_d   = '0;
      act_d   = act_q;
      shd_d   = shd_q;
      pend_d  = pend_q;
      tick_d  = cnt_en_i && at_wrap;
      clko_d  = cnt_en_i && (cnt_q <= half_div(act_q));
      if (cnt_en_i && !at_wrap) begin
         cnt_d = cnt_q + DIV_W'(1);
      end
      if (apply) begin
         act_d  = shd_q;
         pend_d = 1'b0;
      end
      // A write on the apply cycle lands in the shadow and stays pending.
      if (div_wr_i) begin
         shd_d  = div_val_i;
         pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         act_q  <= DIV_W'(DEFAULT_DIV);
         shd_q  <= DIV_W'(DEFAULT_DIV);
         pend_q <= 1'b0;
         tick_q <= 1'b0;
         clko_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         act_q  <= act_d;
         shd_q  <= shd_d;
         pend_q <= pend_d;
         tick_q <= tick_d;
         clko_q <= clko_d;
      end
   end

   assign tick_o    = tick_q;
   assign clk_out_o = clko_q;
   assign pending_o = pend_q;

endmodule

// File: rtl/clk_en_gen.sv
// Clock-enable generator top: oscillator power-up FSM with warm-up counter,
// run/enable qualifier, and NUM_CH independent divider channels.
module clk_en_gen
   import clk_gen_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int DIV_W       = DEF_DIV_W,
   parameter int PU_DELAY    = 16,
   parameter int DEFAULT_DIV = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pu,
   input  logic              en,
   input  logic [NUM_CH-1:0] div_wr,
   input  logic [DIV_W-1:0]  div_val,
   output logic              ready,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] pending
);

   localparam int WCNT_W = (PU_DELAY > 1) ? $clog2(PU_DELAY) : 1;

   state_e            state_q, state_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic              ready_q, ready_d;
   logic              cnt_en;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_OFF;
         wcnt_q  <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         ready_q <= ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      unique case (state_q)
         ST_OFF: begin
            if (pu) begin
               state_d = ST_WARMUP;
               wcnt_d  = WCNT_W'(PU_DELAY - 1);
            end
         end
         ST_WARMUP: begin
            if (wcnt_q == '0) begin
               state_d = ST_RUN;
            end else begin
               wcnt_d = wcnt_q - WCNT_W'(1);
            end
         end
         ST_RUN: state_d = ST_RUN;
         default: state_d = ST_OFF;
      endcase
      // Dropping the request overrides everything, including an in-flight warm-up.
      if (!pu) begin
         state_d = ST_OFF;
         wcnt_d  = '0;
      end
      ready_d = pu && (state_q == ST_RUN);
   end

   // Including pu here clears the channel outputs on the same edge the FSM leaves RUN.
   assign cnt_en = pu && en && (state_q == ST_RUN);
   assign ready  = ready_q;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clk_div_chan #(
         .DIV_W       (DIV_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .cnt_en_i  (cnt_en),
         .div_wr_i  (div_wr[i]),
         .div_val_i (div_val),
         .tick_o    (tick[i]),
         .clk_out_o (clk_out[i]),
         .pending_o (pending[i])
      );
   end

endmodule
